// File: rtl/lspc_vram_cpu_port.sv
// lspc_vram_cpu_port: CPU-side VRAM engine with auto-incrementing pointer,
// slot-timed writes to low/high VRAM and prefetch of both read buses.
module lspc_vram_cpu_port #(
    parameter int HIGH_AW = 11
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_SLOT,
    input  logic        WR_VRAM_ADDR,
    input  logic        nVRAM_WRITE_REQ,
    input  logic [15:0] REG_VRAMADDR,
    input  logic [15:0] REG_VRAMMOD,
    input  logic [15:0] REG_VRAMRW,
    input  logic [15:0] VRAM_LOW_DIN,
    input  logic [15:0] VRAM_HIGH_DIN,
    output logic        VRAM_WRITE_ACK,
    output logic [15:0] CPU_VRAM_ADDR,
    output logic [15:0] CPU_VRAM_WDATA,
    output logic        CPU_VRAM_WE_LOW,
    output logic        CPU_VRAM_WE_HIGH,
    output logic        CPU_VRAM_RD,
    output logic [15:0] VRAM_LOW_READ,
    output logic [15:0] VRAM_HIGH_READ,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_CAP} state_t;

    state_t      state, state_nxt;
    logic [15:0] ptr;
    logic        wr_addr_d, load_now, load_pend, ack_lock, pend_clr;
    logic        wr_slot, load_edge;

    if (HIGH_AW < 1 || HIGH_AW > 15) begin : g_chk
        $error("HIGH_AW must be within 1..15");
    end

    assign load_edge        = WR_VRAM_ADDR & ~wr_addr_d;
    assign wr_slot          = (state == WR_WAIT) & CPU_SLOT;
    assign CPU_VRAM_WE_LOW  = wr_slot & ~ptr[15];
    assign CPU_VRAM_WE_HIGH = wr_slot & ptr[15];
    assign CPU_VRAM_RD      = (state == RD_WAIT) & CPU_SLOT;
    assign CPU_VRAM_ADDR    = ptr;
    assign CPU_VRAM_WDATA   = REG_VRAMRW;
    assign BUSY             = (state != IDLE) | load_pend;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pend_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (load_pend) begin
                    state_nxt = RD_WAIT;
                    pend_clr  = 1'b1;
                end else if (!nVRAM_WRITE_REQ && !ack_lock) begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: state_nxt = CPU_SLOT ? RD_WAIT : WR_WAIT;
            RD_WAIT: state_nxt = CPU_SLOT ? RD_CAP : RD_WAIT;
            default: begin
                state_nxt = load_pend ? RD_WAIT : IDLE;
                pend_clr  = load_pend;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // strobe idles high, so the edge detector starts high to avoid a phantom load
            wr_addr_d      <= 1'b1;
            load_now       <= 1'b0;
            load_pend      <= 1'b0;
            ack_lock       <= 1'b0;
            ptr            <= 16'h0000;
            VRAM_WRITE_ACK <= 1'b0;
            VRAM_LOW_READ  <= 16'h0000;
            VRAM_HIGH_READ <= 16'h0000;
        end else begin
            wr_addr_d      <= WR_VRAM_ADDR;
            load_now       <= load_edge;
            load_pend      <= load_edge | (load_pend & ~pend_clr);
            VRAM_WRITE_ACK <= wr_slot;
            ack_lock       <= wr_slot | (ack_lock & ~nVRAM_WRITE_REQ);
            if (load_now)
                ptr <= REG_VRAMADDR;
            else if (wr_slot)
                ptr <= {ptr[15], ptr[14:0] + REG_VRAMMOD[14:0]};
            if (state == RD_CAP) begin
                VRAM_LOW_READ  <= VRAM_LOW_DIN;
                VRAM_HIGH_READ <= VRAM_HIGH_DIN;
            end
        end
    end
endmodule

// File: tb/tb_lspc_vram_cpu_port.sv
// tb_lspc_vram_cpu_port: randomized scenario bench with VRAM environment
// and a pointer/memory reference model.
module tb_lspc_vram_cpu_port;
    localparam int HAW = 11;

    logic        CLK = 0, RESET = 0, CPU_SLOT = 0, WR_VRAM_ADDR = 1, nVRAM_WRITE_REQ = 1;
    logic [15:0] REG_VRAMADDR = 0, REG_VRAMMOD = 1, REG_VRAMRW = 0;
    logic [15:0] VRAM_LOW_DIN, VRAM_HIGH_DIN;
    logic        VRAM_WRITE_ACK, CPU_VRAM_WE_LOW, CPU_VRAM_WE_HIGH, CPU_VRAM_RD, BUSY;
    logic [15:0] CPU_VRAM_ADDR, CPU_VRAM_WDATA, VRAM_LOW_READ, VRAM_HIGH_READ;

    lspc_vram_cpu_port #(.HIGH_AW(HAW)) dut (
        .CLK(CLK), .RESET(RESET), .CPU_SLOT(CPU_SLOT), .WR_VRAM_ADDR(WR_VRAM_ADDR),
        .nVRAM_WRITE_REQ(nVRAM_WRITE_REQ), .REG_VRAMADDR(REG_VRAMADDR),
        .REG_VRAMMOD(REG_VRAMMOD), .REG_VRAMRW(REG_VRAMRW),
        .VRAM_LOW_DIN(VRAM_LOW_DIN), .VRAM_HIGH_DIN(VRAM_HIGH_DIN),
        .VRAM_WRITE_ACK(VRAM_WRITE_ACK), .CPU_VRAM_ADDR(CPU_VRAM_ADDR),
        .CPU_VRAM_WDATA(CPU_VRAM_WDATA), .CPU_VRAM_WE_LOW(CPU_VRAM_WE_LOW),
        .CPU_VRAM_WE_HIGH(CPU_VRAM_WE_HIGH), .CPU_VRAM_RD(CPU_VRAM_RD),
        .VRAM_LOW_READ(VRAM_LOW_READ), .VRAM_HIGH_READ(VRAM_HIGH_READ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;

    typedef struct packed {
        logic        hi;
        logic [15:0] a;
        logic [15:0] d;
    } we_t;

    function automatic logic [15:0] hash(input logic [15:0] a, input logic hi);
        return 16'(a * 16'h9E37 + (hi ? 16'h5A5A : 16'h0)) | 16'h0001;
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] p, input logic [15:0] m);
        return {p[15], 15'(p[14:0] + m[14:0])};
    endfunction

    // VRAM environment: written only by DUT strobes and preload, read data one cycle late
    logic [15:0] low_ram [32768];
    logic [15:0] high_ram [2**HAW];
    logic        ram_init = 0, pl_en = 0;
    logic [14:0] pl_addr = 0;
    logic [15:0] pl_data = 0;
    always @(posedge CLK) begin
        if (!ram_init) begin
            for (int i = 0; i < 32768; i++) low_ram[i] <= hash(16'(i), 1'b0);
            for (int i = 0; i < 2**HAW; i++) high_ram[i] <= hash(16'(i), 1'b1);
            ram_init <= 1;
        end else begin
            if (CPU_VRAM_WE_LOW) low_ram[CPU_VRAM_ADDR[14:0]] <= CPU_VRAM_WDATA;
            if (CPU_VRAM_WE_HIGH) high_ram[CPU_VRAM_ADDR[HAW-1:0]] <= CPU_VRAM_WDATA;
            if (pl_en) low_ram[pl_addr] <= pl_data;
        end
        VRAM_LOW_DIN  <= low_ram[CPU_VRAM_ADDR[14:0]];
        VRAM_HIGH_DIN <= high_ram[CPU_VRAM_ADDR[HAW-1:0]];
    end

    // reference model
    logic [15:0] ref_low [32768];
    logic [15:0] ref_high [2**HAW];
    logic [15:0] mptr = 0, mmod = 1;

    // monitor
    we_t         we_q[$];
    int          ncyc = 0, nack = 0, nrd = 0, nwe_low = 0, we_cyc = -1, ack_cyc = -1;
    logic [15:0] rd_last = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            if (CPU_VRAM_WE_LOW || CPU_VRAM_WE_HIGH) begin
                we_q.push_back('{CPU_VRAM_WE_HIGH, CPU_VRAM_ADDR, CPU_VRAM_WDATA});
                we_cyc = ncyc;
            end
            if (CPU_VRAM_WE_LOW) nwe_low++;
            if (CPU_VRAM_RD) begin
                nrd++;
                rd_last = CPU_VRAM_ADDR;
            end
            if (VRAM_WRITE_ACK) begin
                nack++;
                ack_cyc = ncyc;
            end
        end
        ncyc++;
    end

    // slot generator
    int slot_per = 4, scnt = 0;
    bit slot_en = 1;
    initial forever begin
        @(posedge CLK);
        #1;
        scnt++;
        CPU_SLOT = slot_en && (scnt % slot_per == 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && BUSY; i++) step(1);
        checks++;
        if (BUSY) begin
            failures++;
            $display("FAIL idle_timeout busy=%b exp=0", BUSY);
        end
    endtask

    task automatic wait_ack();
        int i;
        for (i = 0; i < 300 && !VRAM_WRITE_ACK; i++) step(1);
        checks++;
        if (!VRAM_WRITE_ACK) begin
            failures++;
            $display("FAIL ack_timeout ack=0 exp=1");
        end
    endtask

    task automatic do_load(input logic [15:0] a);
        WR_VRAM_ADDR = 0;
        step(3);
        WR_VRAM_ADDR = 1;
        REG_VRAMADDR = a;
        step(1);
        mptr = a;
    endtask

    task automatic set_mod(input logic [15:0] m);
        REG_VRAMMOD = m;
        mmod = m;
    endtask

    task automatic write_req(input logic [15:0] d, input int hold);
        REG_VRAMRW = d;
        nVRAM_WRITE_REQ = 0;
        wait_ack();
        step(hold);
        nVRAM_WRITE_REQ = 1;
        wait_idle();
    endtask

    task automatic model_write(input logic [15:0] d);
        if (mptr[15]) ref_high[mptr[HAW-1:0]] = d;
        else ref_low[mptr[14:0]] = d;
        mptr = nxt(mptr, mmod);
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({VRAM_WRITE_ACK, CPU_VRAM_WE_LOW, CPU_VRAM_WE_HIGH, CPU_VRAM_RD, BUSY,
             CPU_VRAM_ADDR, VRAM_LOW_READ, VRAM_HIGH_READ} !== '0) begin
            failures++;
            $display("FAIL reset_state addr=%h lr=%h hr=%h ack=%b busy=%b exp=all_zero",
                     CPU_VRAM_ADDR, VRAM_LOW_READ, VRAM_HIGH_READ, VRAM_WRITE_ACK, BUSY);
        end
        RESET = 1;
        step(5);
        checks++;
        if (CPU_VRAM_ADDR !== 16'h0000 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_release addr=%h busy=%b exp=0000/0", CPU_VRAM_ADDR, BUSY);
        end
    endtask

    task automatic test_load_prefetch();
        int n0;
        slot_per = 4;
        pl_addr = 15'h1000;
        pl_data = 16'hABCD;
        pl_en = 1;
        step(1);
        pl_en = 0;
        ref_low[16'h1000] = 16'hABCD;
        we_q.delete();
        n0 = nrd;
        do_load(16'h1000);
        wait_idle();
        checks++;
        if (nrd == n0 || rd_last !== 16'h1000) begin
            failures++;
            $display("FAIL load_rd_addr got=%h reads=%0d exp=1000", rd_last, nrd - n0);
        end
        checks++;
        if (VRAM_LOW_READ !== 16'hABCD || VRAM_HIGH_READ !== ref_high[0]) begin
            failures++;
            $display("FAIL load_prefetch lr=%h hr=%h exp=abcd/%h", VRAM_LOW_READ, VRAM_HIGH_READ, ref_high[0]);
        end
        checks++;
        if (we_q.size() != 0 || CPU_VRAM_ADDR !== 16'h1000) begin
            failures++;
            $display("FAIL load_no_we writes=%0d addr=%h exp=0/1000", we_q.size(), CPU_VRAM_ADDR);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        set_mod(16'h0003);
        do_load(16'h0123);
        wait_idle();
        slot_en = 0;
        nVRAM_WRITE_REQ = 0;
        step(3);
        checks++;
        if (BUSY !== 1'b1 || VRAM_LOW_READ !== ref_low[16'h0123]) begin
            failures++;
            $display("FAIL mid_pre busy=%b lr=%h exp=1/%h", BUSY, VRAM_LOW_READ, ref_low[16'h0123]);
        end
        #2 RESET = 0;
        #1;
        checks++;
        if ({VRAM_WRITE_ACK, CPU_VRAM_WE_LOW, CPU_VRAM_WE_HIGH, CPU_VRAM_RD,
             CPU_VRAM_ADDR, VRAM_LOW_READ, VRAM_HIGH_READ} !== '0) begin
            failures++;
            $display("FAIL mid_reset addr=%h lr=%h hr=%h ack=%b exp=all_zero",
                     CPU_VRAM_ADDR, VRAM_LOW_READ, VRAM_HIGH_READ, VRAM_WRITE_ACK);
        end
        nVRAM_WRITE_REQ = 1;
        step(2);
        RESET = 1;
        slot_en = 1;
        mptr = 0;
        n0 = nack;
        we_q.delete();
        step(10);
        checks++;
        if (nack != n0 || we_q.size() != 0 || CPU_VRAM_ADDR !== 16'h0000) begin
            failures++;
            $display("FAIL mid_after acks=%0d writes=%0d addr=%h exp=0/0/0000",
                     nack - n0, we_q.size(), CPU_VRAM_ADDR);
        end
    endtask

    task automatic test_low_wrap();
        set_mod(16'h0001);
        do_load(16'h7FFF);
        wait_idle();
        we_q.delete();
        write_req(16'h1234, 1);
        model_write(16'h1234);
        checks++;
        if (we_q.size() != 1 || we_q[0] !== we_t'({1'b0, 16'h7FFF, 16'h1234})) begin
            failures++;
            $display("FAIL wrap_we writes=%0d got=%h exp=%h", we_q.size(), we_q[0], we_t'({1'b0, 16'h7FFF, 16'h1234}));
        end
        checks++;
        if (ack_cyc != we_cyc + 1) begin
            failures++;
            $display("FAIL wrap_ack_timing ack=%0d exp=%0d", ack_cyc, we_cyc + 1);
        end
        checks++;
        if (CPU_VRAM_ADDR !== 16'h0000 || VRAM_LOW_READ !== ref_low[0]) begin
            failures++;
            $display("FAIL wrap_ptr addr=%h lr=%h exp=0000/%h", CPU_VRAM_ADDR, VRAM_LOW_READ, ref_low[0]);
        end
    endtask

    task automatic test_high_bank();
        int nl0;
        logic [15:0] d;
        we_t exp;
        set_mod(16'h0020);
        do_load(16'h8000);
        wait_idle();
        nl0 = nwe_low;
        for (int k = 0; k < 3; k++) begin
            we_q.delete();
            d = 16'($urandom);
            exp = '{1'b1, mptr, d};
            write_req(d, $urandom_range(0, 2));
            model_write(d);
            checks++;
            if (we_q.size() != 1 || we_q[0] !== exp) begin
                failures++;
                $display("FAIL high_we%0d writes=%0d got=%h exp=%h", k, we_q.size(), we_q[0], exp);
            end
        end
        checks++;
        if (CPU_VRAM_ADDR !== 16'h8060 || nwe_low != nl0) begin
            failures++;
            $display("FAIL high_final addr=%h low_we=%0d exp=8060/0", CPU_VRAM_ADDR, nwe_low - nl0);
        end
        checks++;
        if (VRAM_HIGH_READ !== ref_high[11'h060] || VRAM_LOW_READ !== ref_low[16'h0060]) begin
            failures++;
            $display("FAIL high_prefetch hr=%h lr=%h exp=%h/%h", VRAM_HIGH_READ, VRAM_LOW_READ,
                     ref_high[11'h060], ref_low[16'h0060]);
        end
    endtask

    task automatic test_neg_mod();
        logic [15:0] d;
        d = 16'($urandom);
        set_mod(16'hFFFF);
        do_load(16'h0005);
        wait_idle();
        we_q.delete();
        write_req(d, 0);
        model_write(d);
        checks++;
        if (CPU_VRAM_ADDR !== 16'h0004 || we_q.size() != 1 || we_q[0] !== we_t'({1'b0, 16'h0005, d})) begin
            failures++;
            $display("FAIL neg_mod addr=%h writes=%0d exp=0004/1", CPU_VRAM_ADDR, we_q.size());
        end
    endtask

    task automatic test_hold();
        int n0;
        slot_per = 2;
        set_mod(16'h0001);
        do_load(16'h0100);
        wait_idle();
        we_q.delete();
        n0 = nack;
        write_req(16'h5A5A, 4);
        model_write(16'h5A5A);
        checks++;
        if (nack - n0 != 1 || we_q.size() != 1 || CPU_VRAM_ADDR !== 16'h0101) begin
            failures++;
            $display("FAIL hold_single acks=%0d writes=%0d addr=%h exp=1/1/0101",
                     nack - n0, we_q.size(), CPU_VRAM_ADDR);
        end
    endtask

    task automatic test_load_race();
        int n0;
        logic [15:0] d;
        d = 16'($urandom);
        slot_per = 4;
        set_mod(16'h0003);
        do_load(16'h0300);
        wait_idle();
        slot_en = 0;
        we_q.delete();
        n0 = nack;
        REG_VRAMRW = d;
        nVRAM_WRITE_REQ = 0;
        step(2);
        do_load(16'h2000);
        step(2);
        slot_en = 1;
        wait_ack();
        step(1);
        nVRAM_WRITE_REQ = 1;
        wait_idle();
        model_write(d);
        checks++;
        if (nack - n0 != 1 || we_q.size() != 1 || we_q[0] !== we_t'({1'b0, 16'h2000, d})) begin
            failures++;
            $display("FAIL race_write acks=%0d writes=%0d got=%h exp=%h", nack - n0, we_q.size(),
                     we_q[0], we_t'({1'b0, 16'h2000, d}));
        end
        checks++;
        if (CPU_VRAM_ADDR !== 16'h2003 || VRAM_LOW_READ !== ref_low[16'h2003]) begin
            failures++;
            $display("FAIL race_prefetch addr=%h lr=%h exp=2003/%h", CPU_VRAM_ADDR, VRAM_LOW_READ, ref_low[16'h2003]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, d;
        we_t exp;
        for (int k = 0; k < 8; k++) begin
            slot_per = $urandom_range(2, 5);
            set_mod(16'($urandom));
            a = 16'($urandom);
            do_load(a);
            wait_idle();
            checks++;
            if (CPU_VRAM_ADDR !== a || VRAM_LOW_READ !== ref_low[a[14:0]] || VRAM_HIGH_READ !== ref_high[a[HAW-1:0]]) begin
                failures++;
                $display("FAIL rnd_load%0d addr=%h lr=%h hr=%h exp=%h/%h/%h", k, CPU_VRAM_ADDR, VRAM_LOW_READ,
                         VRAM_HIGH_READ, a, ref_low[a[14:0]], ref_high[a[HAW-1:0]]);
            end
            we_q.delete();
            d = 16'($urandom);
            exp = '{a[15], a, d};
            write_req(d, $urandom_range(0, 3));
            model_write(d);
            checks++;
            if (we_q.size() != 1 || we_q[0] !== exp || CPU_VRAM_ADDR !== mptr) begin
                failures++;
                $display("FAIL rnd_write%0d writes=%0d got=%h addr=%h exp=%h/%h", k, we_q.size(), we_q[0],
                         CPU_VRAM_ADDR, exp, mptr);
            end
            checks++;
            if (VRAM_LOW_READ !== ref_low[mptr[14:0]] || VRAM_HIGH_READ !== ref_high[mptr[HAW-1:0]]) begin
                failures++;
                $display("FAIL rnd_prefetch%0d lr=%h hr=%h exp=%h/%h", k, VRAM_LOW_READ, VRAM_HIGH_READ,
                         ref_low[mptr[14:0]], ref_high[mptr[HAW-1:0]]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ref_low[i] = hash(16'(i), 1'b0);
        for (int i = 0; i < 2**HAW; i++) ref_high[i] = hash(16'(i), 1'b1);
        test_reset();
        test_load_prefetch();
        test_reset_mid();
        test_low_wrap();
        test_high_bank();
        test_neg_mod();
        test_hold();
        test_load_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
